// File: rtl/omsp_spm_query_pkg.sv
// rtl/omsp_spm_query_pkg.sv - shared codes and state encoding for the SPM query sequencer
package omsp_spm_query_pkg;

  localparam logic [2:0] SPM_REQ_NONE      = 3'd0;
  localparam logic [2:0] SPM_REQ_PUB_START = 3'd1;
  localparam logic [2:0] SPM_REQ_PUB_END   = 3'd2;
  localparam logic [2:0] SPM_REQ_SEC_START = 3'd3;
  localparam logic [2:0] SPM_REQ_SEC_END   = 3'd4;

  localparam logic [1:0] WB_R12 = 2'd0;
  localparam logic [1:0] WB_R13 = 2'd1;
  localparam logic [1:0] WB_R14 = 2'd2;
  localparam logic [1:0] WB_R15 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FETCH,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/omsp_spm_query.sv
// rtl/omsp_spm_query.sv - sequences an SPM layout lookup and writes the result to r12..r15
module omsp_spm_query
  import omsp_spm_query_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NB_FIELDS     = 4
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        query_start,
  input  logic [15:0] query_addr,
  input  logic        query_abort,
  output logic [15:0] lookup_addr,
  output logic [2:0]  data_request,
  input  logic        spm_select_valid,
  input  logic [15:0] requested_data,
  output logic        wb_en,
  output logic [1:0]  wb_reg_sel,
  output logic [15:0] wb_data,
  input  logic        wb_ready,
  output logic        busy,
  output logic        done,
  output logic        found
);

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);
  localparam logic [1:0] IDX_LAST    = 2'(NB_FIELDS - 1);

  state_t      state, state_nxt;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [1:0]  idx;
  logic [2:0]  settle_cnt;
  logic        hit_q;
  logic        found_q;
  logic        abort_now;

  assign abort_now = (state != ST_IDLE) && query_abort;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (query_start) state_nxt = ST_SELECT;
      ST_SELECT: if (settle_cnt == SETTLE_LAST) state_nxt = spm_select_valid ? ST_FETCH : ST_WB;
      ST_FETCH:  state_nxt = ST_WB;
      ST_WB: begin
        if (wb_ready) state_nxt = (!hit_q || idx == IDX_LAST) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort_now) state_nxt = ST_IDLE;
  end

  // The not-found case reuses idx as the r15 selector, so wb_reg_sel is always idx.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      addr_q     <= '0;
      data_q     <= '0;
      idx        <= '0;
      settle_cnt <= '0;
      hit_q      <= 1'b0;
      found_q    <= 1'b0;
    end else if (abort_now) begin
      found_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (query_start) begin
            addr_q     <= query_addr;
            settle_cnt <= '0;
            found_q    <= 1'b0;
          end
        end
        ST_SELECT: begin
          settle_cnt <= settle_cnt + 3'd1;
          if (settle_cnt == SETTLE_LAST) begin
            if (spm_select_valid) begin
              hit_q <= 1'b1;
              idx   <= WB_R12;
            end else begin
              hit_q  <= 1'b0;
              idx    <= WB_R15;
              data_q <= '0;
            end
          end
        end
        ST_FETCH: data_q <= requested_data;
        ST_WB: begin
          if (wb_ready && hit_q) begin
            if (idx == IDX_LAST) found_q <= 1'b1;
            else                 idx     <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lookup_addr  = '0;
    data_request = SPM_REQ_NONE;
    wb_en        = 1'b0;
    wb_reg_sel   = '0;
    wb_data      = '0;
    if (state == ST_SELECT || state == ST_FETCH || state == ST_WB) lookup_addr = addr_q;
    if (state == ST_FETCH) data_request = {1'b0, idx} + 3'd1;
    if (state == ST_WB) begin
      wb_en      = 1'b1;
      wb_reg_sel = idx;
      wb_data    = data_q;
    end
  end

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE) && !query_abort;
  assign found = found_q;

endmodule

// File: tb/tb_omsp_spm_query.sv
// tb/tb_omsp_spm_query.sv - randomized scoreboard bench for omsp_spm_query
module tb_omsp_spm_query;

  localparam int SETTLE = 1;
  localparam int NBF    = 4;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic        query_start;
  logic [15:0] query_addr;
  logic        query_abort;
  logic [15:0] lookup_addr;
  logic [2:0]  data_request;
  logic        spm_select_valid;
  logic [15:0] requested_data;
  logic        wb_en;
  logic [1:0]  wb_reg_sel;
  logic [15:0] wb_data;
  logic        wb_ready;
  logic        busy;
  logic        done;
  logic        found;

  omsp_spm_query #(.SETTLE_CYCLES(SETTLE), .NB_FIELDS(NBF)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .query_start(query_start), .query_addr(query_addr),
    .query_abort(query_abort), .lookup_addr(lookup_addr), .data_request(data_request),
    .spm_select_valid(spm_select_valid), .requested_data(requested_data), .wb_en(wb_en),
    .wb_reg_sel(wb_reg_sel), .wb_data(wb_data), .wb_ready(wb_ready), .busy(busy),
    .done(done), .found(found)
  );

  always #5 mclk = ~mclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit cur_hit = 0;
  logic [17:0] exp_q[$];
  bit          fq[$];
  logic [15:0] spm_tab [0:2][0:3];

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: an SPM owns an address if it falls in its public or secret range.
  function automatic bit spm_lookup(input logic [15:0] a, output int k);
    k = 0;
    for (int i = 0; i < 3; i++) begin
      if ((a >= spm_tab[i][0] && a < spm_tab[i][1]) || (a >= spm_tab[i][2] && a < spm_tab[i][3])) begin
        k = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always_comb begin
    int k;
    spm_select_valid = spm_lookup(lookup_addr, k);
    requested_data   = 16'hDEAD;
    if (spm_select_valid && data_request >= 3'd1 && data_request <= 3'd4)
      requested_data = spm_tab[k][data_request - 3'd1];
  end

  logic        stall_prev = 1'b0;
  logic [1:0]  prev_sel;
  logic [15:0] prev_data;

  always @(negedge mclk) begin
    if (puc_rst_n) begin
      if (wb_en && stall_prev) begin
        chk("wb_hold_sel", 32'(wb_reg_sel), 32'(prev_sel));
        chk("wb_hold_data", 32'(wb_data), 32'(prev_data));
      end
      if (wb_en && wb_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'({wb_reg_sel, wb_data}), 32'h0);
          n_err += (wb_reg_sel == 0 && wb_data == 0) ? 1 : 0;
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("wb_reg_sel", 32'(wb_reg_sel), 32'(e[17:16]));
          chk("wb_data", 32'(wb_data), 32'(e[15:0]));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (fq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          bit f;
          f = fq.pop_front();
          chk("found", 32'(found), 32'(f));
        end
      end
      if (data_request != 3'd0 && !cur_hit) chk("req_when_not_found", 32'(data_request), 32'h0);
      stall_prev = wb_en && !wb_ready && !query_abort;
      prev_sel   = wb_reg_sel;
      prev_data  = wb_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // mode: 0 ready tied high, 1 random ready, 2 stall r13 for 3 cycles, 3 abort at code 2, 4 reset in WB
  task automatic run_query(input logic [15:0] a, input int mode, input bit dup);
    int k, d0, lat;
    bit hit, dupd, cut;
    int stalls;
    hit = spm_lookup(a, k);
    if (hit) for (int i = 0; i < NBF; i++) exp_q.push_back({2'(i), spm_tab[k][i]});
    else exp_q.push_back({2'd3, 16'h0000});
    fq.push_back(hit);
    cur_hit = hit;
    d0 = done_cnt; dupd = 0; cut = 0; stalls = 0;
    query_addr = a; query_start = 1'b1;
    wb_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    lat = cyc;
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      @(posedge mclk); #1;
      query_start = 1'b0;
      if (dup && wb_en && !dupd) begin
        query_start = 1'b1; query_addr = a ^ 16'h5A5A; dupd = 1;
      end
      wb_ready = 1'b1;
      if (mode == 1) wb_ready = 1'($urandom_range(0, 1));
      if (mode == 2 && wb_en && wb_reg_sel == 2'd1 && stalls < 3) begin
        wb_ready = 1'b0; stalls++;
      end
      if (mode == 3 && data_request == 3'd2) begin
        query_abort = 1'b1;
        @(posedge mclk); #1;
        query_abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_found", 32'(found), 32'h0);
        cut = 1; break;
      end
      if (mode == 4 && wb_en) begin
        #2 puc_rst_n = 1'b0;
        #1;
        chk("rst_wb_en", 32'(wb_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge mclk); #1;
        puc_rst_n = 1'b1;
        cut = 1; break;
      end
    end
    if (cut) begin
      exp_q.delete(); fq.delete();
      repeat (5) @(posedge mclk);
      #1;
      chk("no_done_after_cut", 32'(done_cnt), 32'(d0));
      chk("idle_after_cut", 32'(busy), 32'h0);
    end else if (done_cnt == d0) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got no done expected done for addr %h", a);
      exp_q.delete(); fq.delete();
    end else begin
      if (mode == 0 || mode == 2)
        chk("latency", 32'(done_cyc - lat),
            32'((hit ? SETTLE + 2 * NBF + 1 : SETTLE + 2) + (mode == 2 ? 3 : 0)));
      chk("writes_left", 32'(exp_q.size()), 32'h0);
      chk("busy_after_done", 32'(busy), 32'h0);
    end
    wb_ready = 1'b1;
  endtask

  initial begin
    spm_tab = '{'{16'h8000, 16'h8100, 16'hA000, 16'hA100},
                '{16'hC000, 16'hC200, 16'hD000, 16'hD080},
                '{16'h1000, 16'h1010, 16'h2000, 16'h2040}};
    puc_rst_n = 1'b0; query_start = 1'b0; query_addr = '0; query_abort = 1'b0; wb_ready = 1'b1;
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_lookup_addr", 32'(lookup_addr), 32'h0);
    chk("rst_data_request", 32'(data_request), 32'h0);
    chk("rst_wb_en", 32'(wb_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_found", 32'(found), 32'h0);
    puc_rst_n = 1'b1;
    @(posedge mclk); #1;

    run_query(16'h8010, 0, 0);
    chk("found_held", 32'(found), 32'h1);
    run_query(16'h4000, 0, 0);
    chk("notfound_held", 32'(found), 32'h0);
    run_query(16'hC100, 2, 0);
    run_query(16'h8020, 3, 0);
    run_query(16'h1005, 0, 1);
    run_query(16'hD010, 4, 0);
    run_query(16'hA010, 0, 0);

    for (int n = 0; n < 24; n++) begin
      int k;
      logic [15:0] a;
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        a = spm_tab[k][0] + 16'($urandom_range(0, int'(spm_tab[k][1] - spm_tab[k][0]) - 1));
      else
        a = 16'($urandom);
      run_query(a, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/omsp_spm_query.md
Name: omsp_spm_query

Overview:
- Initiator side of the SPM data-request interface; sequences the lookup of one protected module's layout for a "query SPM" instruction.
- Drives a lookup address and `data_request` codes toward the SPM controller, then samples `spm_select_valid` and `requested_data`.
- Returns the four layout words to the register file (r12..r15) over a valid/ready write-back handshake.
- Sits between the execution-unit instruction decoder and the SPM controller. The CPU is stalled while `busy`.

Parameters:
- SETTLE_CYCLES, 1: cycles the lookup address is held with `data_request`=0 before `spm_select_valid` is sampled (range 1..7).
- NB_FIELDS, 4: layout words fetched; fixed codes 1..NB_FIELDS, written to r12..r(12+NB_FIELDS-1).

Ports:
- mclk  in  1  core clock; all state on rising edge.
- puc_rst_n  in  1  asynchronous, active-low reset.
- query_start  in  1  one-cycle request pulse from the decoder.
- query_addr  in  16  address whose owning SPM is looked up; captured on accepted start.
- query_abort  in  1  IRQ/violation abort; highest priority.
- lookup_addr  out  16  address presented to the SPM controller for selection.
- data_request  out  3  0=idle, 1=public start, 2=public end, 3=secret start, 4=secret end.
- spm_select_valid  in  1  some SPM matched lookup_addr.
- requested_data  in  16  combinational field value from the selected SPM.
- wb_en  out  1  write-back valid.
- wb_reg_sel  out  2  0..3 selects r12..r15.
- wb_data  out  16  write-back value.
- wb_ready  in  1  register file accepts the write this cycle.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- found  out  1  result flag; valid when done=1 and held until the next accepted start.

Behaviour:
- Reset (puc_rst_n=0, async):
  - state=IDLE.
  - All outputs 0: lookup_addr, data_request, wb_*, busy, done, found.
  - Internal addr_q, data_q, idx, settle_cnt cleared.
- States: IDLE, SELECT, FETCH, WB, DONE.
- IDLE:
  - query_start=1 → addr_q<=query_addr, settle_cnt<=0, found<=0, next SELECT.
  - query_start is ignored in every other state; no queuing.
- SELECT:
  - lookup_addr=addr_q, data_request=0; settle_cnt increments each cycle.
  - On the cycle settle_cnt==SETTLE_CYCLES-1, spm_select_valid is sampled:
    - 1 → idx<=0, next FETCH.
    - 0 → next WB with not-found payload: a single write of 16'h0000 to r15 (wb_reg_sel=3).
- FETCH:
  - data_request=idx+1, lookup_addr=addr_q.
  - data_q<=requested_data at the end of the cycle; next WB.
  - Exactly one cycle per field.
- WB:
  - wb_en=1, wb_reg_sel=idx, wb_data=data_q; data_request=0; lookup_addr is held.
  - wb_en/wb_reg_sel/wb_data stay stable until wb_ready=1.
  - On the handshake cycle: idx==NB_FIELDS-1 → DONE with found<=1; else idx<=idx+1 → FETCH.
  - Not-found write: handshake → DONE with found=0.
- DONE: done=1 for one cycle; lookup_addr<=0; next IDLE.
- Abort: query_abort=1 in any non-IDLE state → IDLE next cycle.
  - wb_en drops without a handshake; no done pulse; found=0.
  - A write already handshaken in the same cycle counts as committed.
  - Abort has priority over wb_ready.
- Latency, found case with wb_ready tied 1: start at cycle 0.
  - SELECT occupies cycles 1..SETTLE_CYCLES.
  - Then FETCH/WB pairs, so the last write lands at cycle SETTLE_CYCLES+2*NB_FIELDS.
  - done follows in the next cycle: cycle 10 for default parameters.
- Widths: idx is 2 bits with no wrap beyond NB_FIELDS-1. settle_cnt is 3 bits.
- Reset mid-operation: immediate return to reset values; any pending write is lost.

Decomposition:
- Shared package/defines:
  - data_request codes (SPM_REQ_NONE/PUB_START/PUB_END/SEC_START/SEC_END).
  - FSM state encoding.
  - Register index constants (WB_R12..WB_R15).
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Found, no backpressure: query_addr=16'h8010 with SPM 0x8000–0x80FF public, 0xA000–0xA0FF secret, wb_ready=1 → writes r12=8000, r13=8100, r14=A000, r15=A100 in order (values as returned by the model); done at cycle 10; found=1.
- Not found: query_addr=16'h4000 with no matching SPM → single write r15=0000; done=1; found=0; data_request never leaves 0.
- Backpressure: wb_ready low for 3 cycles on the r13 write → wb_en/wb_reg_sel=1/wb_data held stable; no FETCH of code 3 until the handshake; total latency +3.
- Abort mid-FETCH (code 2): query_abort=1 → IDLE next cycle; no further writes; done never pulses; busy=0.
- Start while busy: second query_start during WB is ignored; only the first address's four writes occur.
- Async reset during WB: puc_rst_n=0 mid-cycle → wb_en=0 and busy=0 immediately, without waiting for a clock edge; after release, a new query runs normally.
